// File: rtl/sobel_lb_ctrl_if.sv
// Port bundle for sobel_lb_ctrl: incoming video timing, line-FIFO controls and the 3x3 window strobe.
// The video source is the master; the sequencer uses the slave view.
interface sobel_lb_ctrl_if #(
  parameter int XW = 11,
  parameter int YW = 10
);
  logic          pix_vs;
  logic          pix_de;
  logic [7:0]    pix_data;
  logic          lb_rst;
  logic [7:0]    lb_wr_data;
  logic          lb0_wr_en;
  logic          lb0_rd_en;
  logic          lb1_wr_en;
  logic          lb1_rd_en;
  logic          win_de;
  logic [XW-1:0] win_x;
  logic [YW-1:0] win_y;
  logic          win_border;
  logic          line_err;
  logic          frame_done;

  modport master (
    output pix_vs, pix_de, pix_data,
    input  lb_rst, lb_wr_data, lb0_wr_en, lb0_rd_en, lb1_wr_en, lb1_rd_en,
    input  win_de, win_x, win_y, win_border, line_err, frame_done
  );

  modport slave (
    input  pix_vs, pix_de, pix_data,
    output lb_rst, lb_wr_data, lb0_wr_en, lb0_rd_en, lb1_wr_en, lb1_rd_en,
    output win_de, win_x, win_y, win_border, line_err, frame_done
  );
endinterface

// File: rtl/sobel_lb_ctrl.sv
// Line-buffer sequencer for the Sobel stage: tracks frame/line/column, drives both line FIFOs and the window strobe.
// Optional feature macro SOBEL_LB_BORDER_EN: when defined win_border flags edge windows, otherwise it is tied low.
module sobel_lb_ctrl #(
  parameter int H_PIXELS     = 1280,
  parameter int V_LINES      = 720,
  parameter int FLUSH_CYCLES = 4,
  parameter int XW           = 11,
  parameter int YW           = 10
) (
  input  logic           clk,
  input  logic           rst,
  sobel_lb_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, FLUSH, FILL0, FILL1, RUN} state_t;

  localparam int            FW     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0] F_LAST = FW'(FLUSH_CYCLES - 1);
  localparam logic [XW-1:0] X_LEN  = XW'(H_PIXELS);
  localparam logic [XW-1:0] X_MAX  = XW'(H_PIXELS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_LINES - 1);

  state_t        state, state_nxt;
  logic          done_nxt;
  logic [FW-1:0] flush_cnt;
  logic          vs_d1, de_d1;
  logic          vs_rise, de_fall;
  logic          active, flush_last, line_bad;
  logic [XW-1:0] col;
  logic          col_ovf;
  logic [YW-1:0] line;
  logic          line_err;
  logic          frame_done;

  logic [7:0]    data_p1;
  logic          wr0_p1, rd0_p1, vld_p1;
  logic [XW-1:0] x_p1;
  logic [YW-1:0] y_p1;
  logic          wr1_p2, vld_p2;
  logic [XW-1:0] x_p2;
  logic [YW-1:0] y_p2;
  logic          vld_p3;
  logic [XW-1:0] x_p3;
  logic [YW-1:0] y_p3;

  function automatic logic [XW-1:0] sat_x(input logic [XW-1:0] c);
    return (c > X_MAX) ? X_MAX : c;
  endfunction

  assign vs_rise    = bus.pix_vs & ~vs_d1;
  assign de_fall    = ~bus.pix_de & de_d1;
  assign active     = (state == FILL0) || (state == FILL1) || (state == RUN);
  assign flush_last = (flush_cnt == F_LAST);
  // A line is bad if it stopped short or ran past H_PIXELS (col saturates, so overrun is flagged separately).
  assign line_bad   = (col != X_LEN) || col_ovf;

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    if (vs_rise) begin
      state_nxt = FLUSH;
    end else begin
      case (state)
        FLUSH:   if (flush_last) state_nxt = FILL0;
        FILL0:   if (de_fall) state_nxt = FILL1;
        FILL1:   if (de_fall) state_nxt = RUN;
        RUN: begin
          if (de_fall && (line == Y_LAST)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      flush_cnt  <= '0;
      vs_d1      <= 1'b0;
      de_d1      <= 1'b0;
      col        <= '0;
      col_ovf    <= 1'b0;
      line       <= '0;
      line_err   <= 1'b0;
      frame_done <= 1'b0;
      data_p1    <= '0;
      wr0_p1     <= 1'b0;
      rd0_p1     <= 1'b0;
      vld_p1     <= 1'b0;
      wr1_p2     <= 1'b0;
      vld_p2     <= 1'b0;
      vld_p3     <= 1'b0;
      x_p3       <= '0;
      y_p3       <= '0;
    end else begin
      state      <= state_nxt;
      frame_done <= done_nxt;
      vs_d1      <= bus.pix_vs;
      de_d1      <= bus.pix_de;
      flush_cnt  <= (state == FLUSH && !vs_rise && !flush_last) ? flush_cnt + 1'b1 : '0;

      if (!active || de_fall) begin
        col     <= '0;
        col_ovf <= 1'b0;
      end else if (bus.pix_de) begin
        if (col == X_LEN) col_ovf <= 1'b1;
        else              col     <= col + 1'b1;
      end

      if (state == FLUSH)          line <= '0;
      else if (active && de_fall)  line <= line + 1'b1;

      if (state == FLUSH)                     line_err <= 1'b0;
      else if (active && de_fall && line_bad) line_err <= 1'b1;

      // p1: register pixel and gate enables by the state the pixel arrived in
      data_p1 <= bus.pix_data;
      wr0_p1  <= bus.pix_de & active;
      rd0_p1  <= bus.pix_de & ((state == FILL1) || (state == RUN));
      vld_p1  <= bus.pix_de & (state == RUN);
      // p2: FIFO0 read data lands here (read latency 1)
      wr1_p2  <= rd0_p1;
      vld_p2  <= vld_p1;
      // p3: FIFO1 read data lands here, aligned with the window strobe
      vld_p3  <= vld_p2;
      x_p3    <= x_p2;
      y_p3    <= y_p2;
    end
  end

  always_ff @(posedge clk) begin
    x_p1 <= sat_x(col);
    y_p1 <= line;
    x_p2 <= x_p1;
    y_p2 <= y_p1;
  end

`ifdef SOBEL_LB_BORDER_EN
  logic border_p3;

  function automatic logic is_border(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return (x == '0) || (x == X_MAX) || (y == YW'(2)) || (y == Y_LAST);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) border_p3 <= 1'b0;
    else     border_p3 <= vld_p2 & is_border(x_p2, y_p2);
  end

  assign bus.win_border = border_p3;
`else
  assign bus.win_border = 1'b0;
`endif

  assign bus.lb_rst     = (state == FLUSH);
  assign bus.lb_wr_data = data_p1;
  assign bus.lb0_wr_en  = wr0_p1;
  assign bus.lb0_rd_en  = rd0_p1;
  assign bus.lb1_wr_en  = wr1_p2;
  assign bus.lb1_rd_en  = vld_p2;
  assign bus.win_de     = vld_p3;
  assign bus.win_x      = x_p3;
  assign bus.win_y      = y_p3;
  assign bus.line_err   = line_err;
  assign bus.frame_done = frame_done;
endmodule

// File: tb/tb_sobel_lb_ctrl.sv
// Bench for sobel_lb_ctrl: frame-level stimulus with a per-pixel expectation model and literal count checks.
module tb_sobel_lb_ctrl;
  localparam int H  = 8;
  localparam int V  = 4;
  localparam int F  = 4;
  localparam int XW = 11;
  localparam int YW = 10;
  localparam int N  = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sobel_lb_ctrl_if #(.XW(XW), .YW(YW)) bus ();

  sobel_lb_ctrl #(
    .H_PIXELS(H), .V_LINES(V), .FLUSH_CYCLES(F), .XW(XW), .YW(YW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Expected outputs indexed by cycle, filled in as pixels and syncs are driven.
  bit       exp_rst [N];
  bit       exp_wr0 [N];
  bit       exp_rd0 [N];
  bit       exp_wr1 [N];
  bit       exp_rd1 [N];
  bit       exp_win [N];
  bit       exp_done[N];
  int       exp_x   [N];
  int       exp_y   [N];
  int       err_ev  [N];
  bit [7:0] exp_dat [N];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  bit live = 0;
  int lnum = 0;
  bit err_lvl = 0;

  int c_wr0 = 0, c_wr1 = 0, c_win = 0, c_rst = 0, c_done = 0;
  int c_y2 = 0, c_y3 = 0, c_x7 = 0, c_xbig = 0, c_bord = 0;
  int s_wr0, s_wr1, s_win, s_rst, s_done, s_y2, s_y3, s_x7, s_xbig, s_bord;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, req);
    end
  endtask

  task automatic compare_cycle();
    int  c;
    bit  eb;
    c = cyc;
    if (err_ev[c] == 1) err_lvl = 1'b1;
    else if (err_ev[c] == 2) err_lvl = 1'b0;
    chk("lb_rst",     bus.lb_rst,     exp_rst[c]);
    chk("lb_wr_data", bus.lb_wr_data, exp_dat[c]);
    chk("lb0_wr_en",  bus.lb0_wr_en,  exp_wr0[c]);
    chk("lb0_rd_en",  bus.lb0_rd_en,  exp_rd0[c]);
    chk("lb1_wr_en",  bus.lb1_wr_en,  exp_wr1[c]);
    chk("lb1_rd_en",  bus.lb1_rd_en,  exp_rd1[c]);
    chk("win_de",     bus.win_de,     exp_win[c]);
    chk("frame_done", bus.frame_done, exp_done[c]);
    chk("line_err",   bus.line_err,   err_lvl);
    if (exp_win[c]) begin
      chk("win_x", bus.win_x, exp_x[c]);
      chk("win_y", bus.win_y, exp_y[c]);
    end
`ifdef SOBEL_LB_BORDER_EN
    eb = exp_win[c] && (exp_x[c] == 0 || exp_x[c] == H-1 || exp_y[c] == 2 || exp_y[c] == V-1);
`else
    eb = 1'b0;
`endif
    chk("win_border", bus.win_border, eb);
    c_wr0  += int'(bus.lb0_wr_en);
    c_wr1  += int'(bus.lb1_wr_en);
    c_rst  += int'(bus.lb_rst);
    c_done += int'(bus.frame_done);
    c_bord += int'(bus.win_border);
    if (bus.win_de) begin
      c_win++;
      if (bus.win_y == 2) c_y2++;
      if (bus.win_y == 3) c_y3++;
      if (bus.win_x == 7) c_x7++;
      if (bus.win_x > H-1) c_xbig++;
    end
  endtask

  // A reset at cycle c wipes everything still in flight.
  task automatic kill(input int c);
    for (int i = 1; i <= 3; i++) begin
      exp_wr0[c+i] = 0; exp_rd0[c+i] = 0; exp_wr1[c+i] = 0;
      exp_rd1[c+i] = 0; exp_win[c+i] = 0; exp_done[c+i] = 0;
      err_ev[c+i] = 0;
    end
    for (int i = 1; i <= F; i++) exp_rst[c+i] = 0;
    err_ev[c+1] = 2;
  endtask

  task automatic step();
    exp_dat[cyc+1] = rst ? 8'd0 : bus.pix_data;
    if (rst) kill(cyc);
    @(posedge clk);
    cyc++;
    #1;
    compare_cycle();
  endtask

  task automatic snap();
    s_wr0 = c_wr0; s_wr1 = c_wr1; s_win = c_win; s_rst = c_rst; s_done = c_done;
    s_y2 = c_y2; s_y3 = c_y3; s_x7 = c_x7; s_xbig = c_xbig; s_bord = c_bord;
  endtask

  task automatic vs_start();
    bus.pix_vs = 1'b1;
    for (int i = 1; i <= F; i++) exp_rst[cyc+i] = 1;
    err_ev[cyc+2] = 2;
    live = 1;
    lnum = 0;
    step();
    bus.pix_vs = 1'b0;
    repeat (5) step();
  endtask

  task automatic drive_line(input int n, input int rst_at);
    int t;
    t = cyc;
    for (int k = 0; k < n; k++) begin
      bus.pix_de   = 1'b1;
      bus.pix_data = 8'($urandom);
      if (live) begin
        exp_wr0[cyc+1] = 1;
        if (lnum >= 1) begin
          exp_rd0[cyc+1] = 1;
          exp_wr1[cyc+2] = 1;
        end
        if (lnum >= 2) begin
          exp_rd1[cyc+2] = 1;
          exp_win[cyc+3] = 1;
          exp_x[cyc+3]   = (k < H) ? k : H-1;
          exp_y[cyc+3]   = lnum;
        end
      end
      rst = (k == rst_at);
      if (rst) live = 0;
      t = cyc;
      step();
      if (k == rst_at) begin
        chk("rst_lb0_wr_en", bus.lb0_wr_en, 0);
        chk("rst_lb1_rd_en", bus.lb1_rd_en, 0);
        chk("rst_win_de",    bus.win_de,    0);
        chk("rst_win_x",     bus.win_x,     0);
        chk("rst_win_y",     bus.win_y,     0);
        chk("rst_lb_rst",    bus.lb_rst,    0);
      end
    end
    rst = 1'b0;
    bus.pix_de = 1'b0;
    if (live) begin
      if (n != H) err_ev[t+2] = 1;
      if (lnum == V-1) begin
        exp_done[t+2] = 1;
        live = 0;
      end
      lnum++;
    end
    repeat ($urandom_range(4, 1)) step();
  endtask

  task automatic frame(input int l0, input int l1, input int l2, input int l3);
    vs_start();
    drive_line(l0, -1);
    drive_line(l1, -1);
    drive_line(l2, -1);
    drive_line(l3, -1);
    repeat (4) step();
  endtask

  function automatic int rand_len();
    int r;
    r = int'($urandom_range(5, 0));
    return (r == 0) ? H-1 : (r == 1) ? H+1 : H;
  endfunction

  initial begin
    bus.pix_vs = 1'b0;
    bus.pix_de = 1'b0;
    bus.pix_data = 8'd0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (3) step();

    // pix_de without a frame sync must stay inert
    snap();
    drive_line(H, -1);
    repeat (3) step();
    chk("idle_wr0", c_wr0 - s_wr0, 0);
    chk("idle_win", c_win - s_win, 0);

    // nominal frame
    snap();
    frame(H, H, H, H);
    chk("nom_lb_rst_cycles", c_rst - s_rst, 4);
    chk("nom_wr0_count",  c_wr0 - s_wr0, 32);
    chk("nom_wr1_count",  c_wr1 - s_wr1, 24);
    chk("nom_win_count",  c_win - s_win, 16);
    chk("nom_y2_count",   c_y2 - s_y2, 8);
    chk("nom_y3_count",   c_y3 - s_y3, 8);
    chk("nom_done_count", c_done - s_done, 1);
    chk("nom_line_err",   bus.line_err, 0);
`ifdef SOBEL_LB_BORDER_EN
    chk("nom_border_count", c_bord - s_bord, 16);
`else
    chk("nom_border_count", c_bord - s_bord, 0);
`endif

    // short line, then a clean frame clears the flag
    frame(H, H-1, H, H);
    chk("short_line_err", bus.line_err, 1);
    snap();
    frame(H, H, H, H);
    chk("clean_line_err", bus.line_err, 0);
    chk("clean_win_count", c_win - s_win, 16);

    // long line in the first windowed row
    snap();
    frame(H, H, H+2, H);
    chk("long_line_err",  bus.line_err, 1);
    chk("long_x7_count",  c_x7 - s_x7, 4);
    chk("long_xbig",      c_xbig - s_xbig, 0);
    chk("long_win_count", c_win - s_win, 18);

    // frame sync before line 2 aborts, then a full frame follows
    snap();
    vs_start();
    drive_line(H, -1);
    drive_line(H, -1);
    frame(H, H, H, H);
    chk("abort_lb_rst_cycles", c_rst - s_rst, 8);
    chk("abort_done_count",    c_done - s_done, 1);
    chk("abort_win_count",     c_win - s_win, 16);

    // randomized frames
    for (int f = 0; f < 6; f++) frame(rand_len(), rand_len(), rand_len(), rand_len());

    // reset in the middle of a windowed line; the rest of the frame is ignored
    vs_start();
    drive_line(H, -1);
    drive_line(H, -1);
    drive_line(H, 3);
    snap();
    drive_line(H, -1);
    drive_line(H, -1);
    repeat (3) step();
    chk("post_rst_wr0", c_wr0 - s_wr0, 0);
    chk("post_rst_win", c_win - s_win, 0);
    chk("post_rst_line_err", bus.line_err, 0);

    snap();
    frame(H, H, H, H);
    chk("recover_win_count",  c_win - s_win, 16);
    chk("recover_done_count", c_done - s_done, 1);

    repeat (5) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
